// File: rtl/arithmetic_seq_unit_if.sv
// ============================================================================
// arithmetic_seq_unit_if : operand/result handshake bundle for arithmetic_seq_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface arithmetic_seq_unit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             wr_en;
  logic             err;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, wr_en, err,
           flag_c, flag_v, flag_z, flag_n
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, wr_en, err,
           flag_c, flag_v, flag_z, flag_n
  );
endinterface

`default_nettype wire

// File: rtl/arithmetic_seq_unit.sv
// ============================================================================
// arithmetic_seq_unit : handshaked ALU with persistent C/V/Z/N flags and shift-add MUL
// Revision: 1.0
// ============================================================================
`default_nettype none

module arithmetic_seq_unit #(
  parameter int WIDTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  arithmetic_seq_unit_if.slave bus
);

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_INC = 4'b0010;
  localparam logic [3:0] c_OP_DEC = 4'b0011;
  localparam logic [3:0] c_OP_CMP = 4'b0100;
  localparam logic [3:0] c_OP_ADC = 4'b0101;
  localparam logic [3:0] c_OP_SBC = 4'b0110;
  localparam logic [3:0] c_OP_MUL = 4'b0111;

  localparam int              CW         = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   c_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0]  c_ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_INC_OVF = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_DEC_OVF = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int              MSB        = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_mul_last;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_wr_en;
  logic             r_err;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_flag_z;
  logic             r_flag_n;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_v;
  logic             w_wr;
  logic             w_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_mul_last   = 1'b0;
    case (r_state)
      S_IDLE:     w_in_ready = 1'b1;
      S_MUL_BUSY: begin
        w_mul_last = (r_cnt == c_CNT_LAST);
        if (w_mul_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_state_next = S_IDLE;
      end
      default:    w_state_next = S_IDLE;
    endcase
    if (rst) w_in_ready = 1'b0;
    w_accept = bus.in_valid && w_in_ready;
    if (w_accept) w_state_next = (bus.op == c_OP_MUL) ? S_MUL_BUSY : S_DONE;
  end

  // Single-cycle datapath: everything is evaluated at WIDTH+1 bits so bit WIDTH is carry/borrow.
  always_comb begin
    w_a_ext = {1'b0, bus.a};
    w_b_ext = {1'b0, bus.b};
    w_cin   = {{WIDTH{1'b0}}, r_flag_c};
    w_sum   = '0;
    w_v     = 1'b0;
    w_wr    = 1'b1;
    w_err   = 1'b0;
    case (bus.op)
      c_OP_ADD: begin
        w_sum = w_a_ext + w_b_ext;
        w_v   = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
      end
      c_OP_ADC: begin
        w_sum = w_a_ext + w_b_ext + w_cin;
        w_v   = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
      end
      c_OP_SUB, c_OP_CMP: begin
        w_sum = w_a_ext - w_b_ext;
        w_v   = (bus.a[MSB] != bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
        w_wr  = (bus.op != c_OP_CMP);
      end
      c_OP_SBC: begin
        w_sum = w_a_ext - w_b_ext - w_cin;
        w_v   = (bus.a[MSB] != bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
      end
      c_OP_INC: begin
        w_sum = w_a_ext + c_ONE;
        w_v   = (bus.a == c_INC_OVF);
      end
      c_OP_DEC: begin
        w_sum = w_a_ext - c_ONE;
        w_v   = (bus.a == c_DEC_OVF);
      end
      c_OP_MUL: w_sum = '0;
      default: begin
        w_wr  = 1'b0;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_wr_en     <= 1'b0;
      r_err       <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
    end else if (w_accept) begin
      if (bus.op == c_OP_MUL) begin
        r_cnt       <= '0;
        r_acc       <= '0;
        r_mcand     <= {{WIDTH{1'b0}}, bus.a};
        r_mplier    <= bus.b;
        r_out_valid <= 1'b0;
        r_wr_en     <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        r_out_valid <= 1'b1;
        r_result    <= w_err ? '0 : w_sum[WIDTH-1:0];
        r_result_hi <= '0;
        r_wr_en     <= w_wr;
        r_err       <= w_err;
        if (!w_err) begin
          r_flag_c <= w_sum[WIDTH];
          r_flag_v <= w_v;
          r_flag_z <= (w_sum[WIDTH-1:0] == '0);
          r_flag_n <= w_sum[MSB];
        end
      end
    end else if (r_state == S_MUL_BUSY) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_mul_last) begin
        r_out_valid <= 1'b1;
        r_result    <= w_acc_next[WIDTH-1:0];
        r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
        r_wr_en     <= 1'b1;
        r_err       <= 1'b0;
        r_flag_c    <= |w_acc_next[2*WIDTH-1:WIDTH];
        r_flag_v    <= |w_acc_next[2*WIDTH-1:WIDTH];
        r_flag_z    <= (w_acc_next[WIDTH-1:0] == '0);
        r_flag_n    <= w_acc_next[MSB];
      end
    end else if (r_state == S_DONE && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_err       <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.wr_en     = r_wr_en;
  assign bus.err       = r_err;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_v    = r_flag_v;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_n    = r_flag_n;

endmodule

`default_nettype wire

// File: tb/tb_arithmetic_seq_unit.sv
// ============================================================================
// tb_arithmetic_seq_unit : directed vectors for arithmetic_seq_unit at WIDTH=4
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arithmetic_seq_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  arithmetic_seq_unit_if #(.WIDTH(4)) bus ();

  arithmetic_seq_unit #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {C,V,Z,N}.
  function automatic logic [3:0] flags();
    return {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op just after an edge, returns the number of edges until out_valid.
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       output int lat, output bit saw_ready);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat          = 1;
    saw_ready    = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) saw_ready = 1'b1;
      step();
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] res, input logic [3:0] hi,
                           input logic [3:0] fl, input logic wr, input logic er);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".result"}, 32'(bus.result), 32'(res));
    chk({tag, ".result_hi"}, 32'(bus.result_hi), 32'(hi));
    chk({tag, ".flags_cvzn"}, 32'(flags()), 32'(fl));
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(wr));
    chk({tag, ".err"}, 32'(bus.err), 32'(er));
  endtask

  initial begin
    int lat;
    bit saw;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 4'h0;
    bus.a         = 4'h0;
    bus.b         = 4'h0;
    repeat (3) step();
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", 32'({bus.result_hi, bus.result}), 32'd0);
    chk("rst.wr_err", 32'({bus.wr_en, bus.err}), 32'd0);
    chk("rst.flags", 32'(flags()), 32'd0);
    rst = 1'b0;
    step();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

    issue(4'b0000, 4'b0111, 4'b0001, lat, saw);
    chk("add_ovf.lat", 32'(lat), 32'd1);
    check_out("add_ovf", 4'b1000, 4'h0, 4'b0101, 1'b1, 1'b0);

    issue(4'b0001, 4'b0000, 4'b0001, lat, saw);
    check_out("sub_borrow", 4'b1111, 4'h0, 4'b1001, 1'b1, 1'b0);

    issue(4'b0100, 4'b0101, 4'b0101, lat, saw);
    check_out("cmp_eq", 4'b0000, 4'h0, 4'b0010, 1'b0, 1'b0);

    issue(4'b0000, 4'b1111, 4'b0001, lat, saw);
    check_out("add_carry", 4'b0000, 4'h0, 4'b1010, 1'b1, 1'b0);

    issue(4'b0101, 4'b0010, 4'b0011, lat, saw);
    check_out("adc_cin", 4'b0110, 4'h0, 4'b0000, 1'b1, 1'b0);

    issue(4'b0001, 4'b0000, 4'b0001, lat, saw);
    issue(4'b0110, 4'b0010, 4'b0001, lat, saw);
    check_out("sbc_bin", 4'b0000, 4'h0, 4'b0010, 1'b1, 1'b0);

    issue(4'b0010, 4'b0111, 4'b0000, lat, saw);
    check_out("inc_ovf", 4'b1000, 4'h0, 4'b0101, 1'b1, 1'b0);

    issue(4'b0011, 4'b0000, 4'b0000, lat, saw);
    check_out("dec_wrap", 4'b1111, 4'h0, 4'b1001, 1'b1, 1'b0);

    issue(4'b0111, 4'b1111, 4'b1111, lat, saw);
    chk("mul.lat", 32'(lat), 32'd5);
    chk("mul.in_ready_busy", 32'(saw), 32'd0);
    check_out("mul_ff", 4'b0001, 4'b1110, 4'b1100, 1'b1, 1'b0);

    issue(4'b0111, 4'b0011, 4'b0101, lat, saw);
    check_out("mul_3x5", 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0);

    issue(4'b0001, 4'b0000, 4'b0001, lat, saw);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 4'b1111, 4'h0, 4'b1001, 1'b1, 1'b0);
      chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("drain.valid", 32'(bus.out_valid), 32'd0);

    issue(4'b1010, 4'b0101, 4'b0011, lat, saw);
    chk("illegal.lat", 32'(lat), 32'd1);
    check_out("illegal", 4'b0000, 4'h0, 4'b1001, 1'b0, 1'b1);

    bus.op       = 4'b0111;
    bus.a        = 4'b0011;
    bus.b        = 4'b0011;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort.valid", 32'(bus.out_valid), 32'd0);
      chk("abort.flags", 32'(flags()), 32'd0);
      step();
    end

    issue(4'b0000, 4'b0001, 4'b0001, lat, saw);
    chk("post_rst.lat", 32'(lat), 32'd1);
    check_out("post_rst_add", 4'b0010, 4'h0, 4'b0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
